// File: rtl/line_tap3.sv
// Three-row tap generator: two cascaded line memories feed the vertically aligned pixels of the
// two previous lines. Optional macro LINE_TAP_REPLICATE_EN selects a replicated top border.
module line_tap3 #(
    parameter int H_ACTIVE = 480,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_hs,
    input  logic              in_vs,
    input  logic              in_de,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_hs,
    output logic              out_vs,
    output logic              out_de,
    output logic [DATA_W-1:0] tap0,
    output logic [DATA_W-1:0] tap1,
    output logic [DATA_W-1:0] tap2,
    output logic [1:0]        rows_valid
);

    // x must be able to park at H_ACTIVE, so it is one state wider than the address
    localparam int X_W = $clog2(H_ACTIVE + 1);
    localparam int A_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [X_W-1:0] X_END = X_W'(H_ACTIVE);

    logic [DATA_W-1:0] mem1 [H_ACTIVE];
    logic [DATA_W-1:0] mem2 [H_ACTIVE];

    logic [X_W-1:0]    x_r;
    logic [1:0]        y_r;
    logic              de_d_r;
    logic              vs_d_r;

    logic              in_range_s;
    logic [A_W-1:0]    idx_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] tap1_s;
    logic [DATA_W-1:0] tap2_s;
    logic [1:0]        rows_s;
    logic              vs_rise_s;
    logic              de_fall_s;

    function automatic logic [1:0] rows_of(input logic [1:0] y);
        if (y > 2'd2) begin
            rows_of = 2'd2;
        end else begin
            rows_of = y;
        end
    endfunction

    // Address decode, memory read and edge detection
    always_comb begin
        in_range_s = (x_r < X_END);
        idx_s      = {A_W{1'b0}};
        if (in_range_s) begin
            idx_s = x_r[A_W-1:0];
        end else begin
            idx_s = {A_W{1'b0}};
        end
        rd1_s     = mem1[idx_s];
        rd2_s     = mem2[idx_s];
        rows_s    = rows_of(y_r);
        vs_rise_s = in_vs & ~vs_d_r;
        de_fall_s = de_d_r & ~in_de;
    end

    // Top-border treatment of history rows that do not yet belong to this frame
    always_comb begin
        tap1_s = rd1_s;
        tap2_s = rd2_s;
`ifdef LINE_TAP_REPLICATE_EN
        case (rows_s)
            2'd0: begin
                tap1_s = in_data;
                tap2_s = in_data;
            end
            2'd1: begin
                tap1_s = rd1_s;
                tap2_s = rd1_s;
            end
            default: begin
                tap1_s = rd1_s;
                tap2_s = rd2_s;
            end
        endcase
`else
        case (rows_s)
            2'd0: begin
                tap1_s = {DATA_W{1'b0}};
                tap2_s = {DATA_W{1'b0}};
            end
            2'd1: begin
                tap1_s = rd1_s;
                tap2_s = {DATA_W{1'b0}};
            end
            default: begin
                tap1_s = rd1_s;
                tap2_s = rd2_s;
            end
        endcase
`endif
    end

    // Line-memory cascade: the old row moves into mem2 as the new pixel lands in mem1
    always_ff @(posedge clk) begin
        if (rst_n && in_de && in_range_s) begin
            mem1[idx_s] <= in_data;
            mem2[idx_s] <= rd1_s;
        end
    end

    // Counters, strobes and tap registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_r        <= {X_W{1'b0}};
            y_r        <= 2'd0;
            de_d_r     <= 1'b0;
            vs_d_r     <= 1'b0;
            out_hs     <= 1'b0;
            out_vs     <= 1'b0;
            out_de     <= 1'b0;
            tap0       <= {DATA_W{1'b0}};
            tap1       <= {DATA_W{1'b0}};
            tap2       <= {DATA_W{1'b0}};
            rows_valid <= 2'd0;
        end else begin
            out_hs <= in_hs;
            out_vs <= in_vs;
            out_de <= in_de;
            de_d_r <= in_de;
            vs_d_r <= in_vs;
            if (in_de) begin
                rows_valid <= rows_s;
                if (in_range_s) begin
                    tap0 <= in_data;
                    tap1 <= tap1_s;
                    tap2 <= tap2_s;
                    x_r  <= x_r + X_W'(1);
                end else begin
                    // Overlong line: park x and blank the taps
                    tap0 <= {DATA_W{1'b0}};
                    tap1 <= {DATA_W{1'b0}};
                    tap2 <= {DATA_W{1'b0}};
                    x_r  <= x_r;
                end
            end else begin
                x_r <= {X_W{1'b0}};
            end
            if (vs_rise_s) begin
                y_r <= 2'd0;
            end else if (de_fall_s && (y_r != 2'd3)) begin
                y_r <= y_r + 2'd1;
            end else begin
                y_r <= y_r;
            end
        end
    end

endmodule

// File: tb/tb_line_tap3.sv
// Self-checking bench for line_tap3 (H_ACTIVE=8): random video against a per-column history model.
module tb_line_tap3;

    localparam int H  = 8;
    localparam int DW = 16;
`ifdef LINE_TAP_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          in_hs   = 1'b0;
    logic          in_vs   = 1'b0;
    logic          in_de   = 1'b0;
    logic [DW-1:0] in_data = 16'h0000;
    logic          out_hs, out_vs, out_de;
    logic [DW-1:0] tap0, tap1, tap2;
    logic [1:0]    rows_valid;

    line_tap3 #(.H_ACTIVE(H), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
        .in_data(in_data), .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
        .tap0(tap0), .tap1(tap1), .tap2(tap2), .rows_valid(rows_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: what each column of the previous two stored lines holds, plus line position
    logic [DW-1:0] prev1 [H];
    logic [DW-1:0] prev2 [H];
    int            col = 0;
    int            line_no = 0;
    logic          was_de = 1'b0;
    logic          was_vs = 1'b0;
    logic          e_hs = 1'b0, e_vs = 1'b0, e_de = 1'b0;
    logic [DW-1:0] e_t0 = '0, e_t1 = '0, e_t2 = '0;
    logic [1:0]    e_rv = 2'd0;
    bit            cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int rv;
        logic [DW-1:0] above1, above2;
        if (!rst_n) begin
            col = 0; line_no = 0; was_de = 1'b0; was_vs = 1'b0;
            e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0;
            e_t0 = '0; e_t1 = '0; e_t2 = '0; e_rv = 2'd0;
            return;
        end
        e_hs = in_hs; e_vs = in_vs; e_de = in_de;
        if (in_de) begin
            rv = (line_no < 2) ? line_no : 2;
            e_rv = 2'(rv);
            if (col < H) begin
                above1 = prev1[col];
                above2 = prev2[col];
                prev2[col] = above1;
                prev1[col] = in_data;
                e_t0 = in_data;
                e_t1 = (rv >= 1) ? above1 : (REP ? in_data : 16'h0000);
                e_t2 = (rv >= 2) ? above2 : (REP ? ((rv == 1) ? above1 : in_data) : 16'h0000);
                col++;
            end else begin
                e_t0 = '0; e_t1 = '0; e_t2 = '0;
            end
        end else begin
            col = 0;
        end
        if (in_vs && !was_vs) line_no = 0;
        else if (was_de && !in_de && line_no < 3) line_no++;
        was_de = in_de;
        was_vs = in_vs;
    endtask

    initial begin
        for (int i = 0; i < H; i++) begin
            prev1[i] = '0;
            prev2[i] = '0;
        end
        forever begin
            @(posedge clk);
            model_step();
            cmp_en = 1'b1;
        end
    end

    // Every-cycle comparison of the DUT against the reference
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("out_hs", 32'(out_hs), 32'(e_hs));
                chk("out_vs", 32'(out_vs), 32'(e_vs));
                chk("out_de", 32'(out_de), 32'(e_de));
                chk("tap0", 32'(tap0), 32'(e_t0));
                chk("tap1", 32'(tap1), 32'(e_t1));
                chk("tap2", 32'(tap2), 32'(e_t2));
                chk("rows_valid", 32'(rows_valid), 32'(e_rv));
            end
        end
    end

    task automatic drive(input logic de, input logic [DW-1:0] d, input logic vs);
        @(negedge clk);
        in_de = de; in_data = d; in_vs = vs; in_hs = ~de;
    endtask

    task automatic gap(input int n);
        repeat (n) drive(1'b0, in_data, 1'b0);
    endtask

    task automatic vs_pulse();
        drive(1'b0, 16'h0000, 1'b1);
        drive(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_line(input int w);
        for (int i = 0; i < w; i++) drive(1'b1, 16'($urandom), 1'b0);
        gap(2);
    endtask

    logic [DW-1:0] ov [10];
    logic [DW-1:0] ml [H];

    initial begin
        // Reset held for 3 clocks with active input
        rst_n = 1'b0; in_de = 1'b1; in_data = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_tap0", 32'(tap0), 32'h0);
            chk("rst_de", 32'(out_de), 32'h0);
            chk("rst_rows", 32'(rows_valid), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1; in_de = 1'b1; in_data = 16'hFFFF;
        settle();
        chk("rel_out_de1", 32'(out_de), 32'h1);
        chk("rel_tap0", 32'(tap0), 32'hFFFF);
        drive(1'b0, 16'h0000, 1'b0);
        settle();
        chk("rel_out_de0", 32'(out_de), 32'h0);

        // Top border on first line of a frame
        vs_pulse();
        for (int x = 0; x < H; x++) begin
            drive(1'b1, 16'h1234, 1'b0);
            if (x == 0) begin
                settle();
                chk("border_tap1", 32'(tap1), REP ? 32'h1234 : 32'h0);
                chk("border_tap2", 32'(tap2), REP ? 32'h1234 : 32'h0);
            end
        end
        gap(2);

        // Ramp frame, lines 0..3
        vs_pulse();
        for (int n = 0; n < 4; n++) begin
            for (int x = 0; x < H; x++) begin
                drive(1'b1, {8'(n), 8'(x)}, 1'b0);
                if (n == 2 && x == 5) begin
                    settle();
                    chk("ramp_tap0", 32'(tap0), 32'h0205);
                    chk("ramp_tap1", 32'(tap1), 32'h0105);
                    chk("ramp_tap2", 32'(tap2), 32'h0005);
                    chk("ramp_rows", 32'(rows_valid), 32'h2);
                end
            end
            gap(2);
        end

        // Frame restart: vs rises in the gap right after line 3
        vs_pulse();
        for (int x = 0; x < H; x++) begin
            drive(1'b1, 16'hAAAA, 1'b0);
            if (x == 3) begin
                settle();
                chk("restart_rows", 32'(rows_valid), 32'h0);
                chk("restart_tap1", 32'(tap1), REP ? 32'hAAAA : 32'h0);
                chk("restart_tap2", 32'(tap2), REP ? 32'hAAAA : 32'h0);
            end
        end
        gap(2);

        // Overlong 10-pixel line, then a line that must see only its first 8 pixels
        for (int x = 0; x < 10; x++) begin
            ov[x] = 16'($urandom) | 16'h0001;
            drive(1'b1, ov[x], 1'b0);
            if (x >= H) begin
                settle();
                chk("ovl_tap0", 32'(tap0), 32'h0);
                chk("ovl_tap1", 32'(tap1), 32'h0);
                chk("ovl_tap2", 32'(tap2), 32'h0);
            end
        end
        gap(2);
        for (int x = 0; x < H; x++) begin
            drive(1'b1, 16'($urandom), 1'b0);
            settle();
            chk("ovl_next_tap1", 32'(tap1), 32'(ov[x]));
        end
        gap(2);

        // Mid-line reset at x=4 of line 2
        vs_pulse();
        rand_line(H);
        rand_line(H);
        for (int x = 0; x < H; x++) begin
            ml[x] = 16'($urandom);
            @(negedge clk);
            rst_n = (x != 4); in_de = 1'b1; in_data = ml[x]; in_vs = 1'b0; in_hs = 1'b0;
            settle();
            if (x == 4) begin
                chk("mrst_tap0", 32'(tap0), 32'h0);
                chk("mrst_rows", 32'(rows_valid), 32'h0);
            end
            if (x == 5) begin
                chk("mrst_after_tap0", 32'(tap0), 32'(ml[5]));
                chk("mrst_after_rows", 32'(rows_valid), 32'h0);
            end
        end
        gap(2);
        for (int x = 0; x < H; x++) begin
            drive(1'b1, 16'($urandom), 1'b0);
            if (x < 3) begin
                settle();
                chk("mrst_next_tap1", 32'(tap1), 32'(ml[x + 5]));
                chk("mrst_next_rows", 32'(rows_valid), 32'h1);
            end
        end
        gap(2);

        // Randomised frames: varied line widths, gaps and frame lengths
        for (int f = 0; f < 40; f++) begin
            vs_pulse();
            for (int l = 0; l < int'($urandom_range(1, 5)); l++) begin
                for (int x = 0; x < ((($urandom_range(0, 3)) == 0) ? int'($urandom_range(1, 11)) : H); x++)
                    drive(1'b1, 16'($urandom), 1'b0);
                gap(int'($urandom_range(1, 3)));
            end
        end
        gap(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
